// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM state type and sizing for the muldiv sequencer
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = 6;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - datapath-facing request/result bundle of the muldiv sequencer
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             stall;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] hiout;
    logic [WIDTH-1:0] loout;

    modport master (
        output start, op, srca, srcb,
        input  busy, stall, done, illegal, hiout, loout
    );

    modport slave (
        input  start, op, srca, srcb,
        output busy, stall, done, illegal, hiout, loout
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring shift-subtract iteration on {acc, q}
// Subtract path present only when MULDIV_SEQUENCER_DIV_EN is defined.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] opnd,
`ifdef MULDIV_SEQUENCER_DIV_EN
    input  logic             is_div,
`endif
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] sum;
`ifdef MULDIV_SEQUENCER_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
`endif

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then shift the pair right.
        sum     = acc_in + (q_in[0] ? {1'b0, opnd} : '0);
        acc_out = {1'b0, sum[WIDTH:1]};
        q_out   = {sum[0], q_in[WIDTH-1:1]};
`ifdef MULDIV_SEQUENCER_DIV_EN
        shifted = {acc_in[WIDTH-1:0], q_in[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        if (is_div) begin
            // A borrow out of the trial subtract means restore the shifted remainder.
            if (diff[WIDTH+1]) begin
                acc_out = shifted;
                q_out   = {q_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = diff[WIDTH:0];
                q_out   = {q_in[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative HI/LO multiply/divide sequencer (IDLE/RUN/FIN)
// Divide ops are built in only with MULDIV_SEQUENCER_DIV_EN; otherwise they pulse illegal.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_res_q, neg_res_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
`ifdef MULDIV_SEQUENCER_DIV_EN
    logic             is_div_q, is_div_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] quo, rem;
`endif

    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_q;
    logic [2*WIDTH-1:0] prod;
    logic               req_div, req_signed, busy;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign req_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    assign req_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg      = req_signed & bus.srca[WIDTH-1];
    assign b_neg      = req_signed & bus.srcb[WIDTH-1];
    assign a_mag      = a_neg ? -bus.srca : bus.srca;
    assign b_mag      = b_neg ? -bus.srcb : bus.srcb;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc_q),
        .q_in    (q_q),
        .opnd    (opnd_q),
`ifdef MULDIV_SEQUENCER_DIV_EN
        .is_div  (is_div_q),
`endif
        .acc_out (step_acc),
        .q_out   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef MULDIV_SEQUENCER_DIV_EN
        is_div_d   = is_div_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        dividend_d = dividend_q;
        quo        = neg_res_q ? -step_q : step_q;
        rem        = neg_rem_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
`endif
        // Sign correction is applied to the final iteration's output at write-back.
        prod = {step_acc[WIDTH-1:0], step_q};
        if (neg_res_q) begin
            prod = -prod;
        end

        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    cnt_d     = '0;
                    acc_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
`ifdef MULDIV_SEQUENCER_DIV_EN
                    state_d    = ST_RUN;
                    is_div_d   = req_div;
                    neg_rem_d  = a_neg;
                    div_zero_d = (bus.srcb == '0);
                    dividend_d = bus.srca;
                    q_d        = req_div ? a_mag : b_mag;
                    opnd_d     = req_div ? b_mag : a_mag;
`else
                    q_d    = b_mag;
                    opnd_d = a_mag;
                    if (req_div) begin
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
`endif
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    cnt_d   = '0;
`ifdef MULDIV_SEQUENCER_DIV_EN
                    if (is_div_q) begin
                        if (div_zero_q) begin
                            lo_d = '1;
                            hi_d = dividend_q;
                        end else begin
                            lo_d = quo;
                            hi_d = rem;
                        end
                    end else
`endif
                    begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_res_q  <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef MULDIV_SEQUENCER_DIV_EN
            is_div_q   <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_res_q  <= neg_res_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
`ifdef MULDIV_SEQUENCER_DIV_EN
            is_div_q   <= is_div_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            dividend_q <= dividend_d;
`endif
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign bus.busy    = busy;
    assign bus.stall   = bus.start & busy;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.hiout   = hi_q;
    assign bus.loout   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_SEQUENCER_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int nvec  = 0;
    int nfail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    localparam logic [1:0]  D_OP [7] = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
    localparam logic [31:0] D_A  [7] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd5,
                                         32'h80000000, 32'hFFFFFFF9, 32'd100};
    localparam logic [31:0] D_B  [7] = '{32'h0000FFFF, 32'd2, 32'd2, 32'd0,
                                         32'hFFFFFFFF, 32'd0, 32'd7};

    // Expected HI/LO from plain integer arithmetic; unsupported ops leave the architectural HI/LO alone.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output bit ill, output int lat);
        logic signed [63:0] p;
        logic signed [31:0] sa, sb;
        ill = 1'b0;
        lat = 33;
        hi  = m_hi;
        lo  = m_lo;
        sa  = a;
        sb  = b;
        case (op)
            OP_MULTU: {hi, lo} = {32'b0, a} * {32'b0, b};
            OP_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {hi, lo} = p;
            end
            default: begin
                if (!DIV_EN) begin
                    ill = 1'b1;
                    lat = 1;
                end else if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF;
                    hi = a;
                end else if (op == OP_DIVU) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo = 32'h80000000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one op from idle (entered #1 after a rising edge) and observe until done or a 40-cycle bound.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output bit ill, output int busy_n, output bit held);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1; busy_n = 0; held = 1'b1; ill = 1'b0; hi = 'x; lo = 'x;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = n;
                hi  = bus.hiout;
                lo  = bus.loout;
                ill = bus.illegal;
            end else if (bus.hiout !== m_hi || bus.loout !== m_lo) begin
                held = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.srca = 32'd3; bus.srcb = 32'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        nvec++; if (bus.stall !== 1'b0) begin nfail++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        nvec++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        nvec++; if (bus.illegal !== 1'b0) begin nfail++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
        nvec++; if (bus.hiout !== 32'd0) begin nfail++; $display("FAIL reset_hi got=%h exp=0", bus.hiout); end
        nvec++; if (bus.loout !== 32'd0) begin nfail++; $display("FAIL reset_lo got=%h exp=0", bus.loout); end
        bus.start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_directed();
        logic [31:0] ehi, elo, hi, lo;
        bit eill, ill, held;
        int elat, lat, bn;
        for (int i = 0; i < 7; i++) begin
            model(D_OP[i], D_A[i], D_B[i], ehi, elo, eill, elat);
            do_op(D_OP[i], D_A[i], D_B[i], lat, hi, lo, ill, bn, held);
            nvec++; if (lat !== elat) begin nfail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
            nvec++; if (hi !== ehi) begin nfail++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, ehi); end
            nvec++; if (lo !== elo) begin nfail++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, elo); end
            nvec++; if (ill !== eill) begin nfail++; $display("FAIL dir%0d_illegal got=%b exp=%b", i, ill, eill); end
            nvec++; if (bn !== (eill ? 0 : 32)) begin nfail++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bn, eill ? 0 : 32); end
            nvec++; if (held !== 1'b1) begin nfail++; $display("FAIL dir%0d_hilo_hold got=%b exp=1", i, held); end
            m_hi = ehi; m_lo = elo;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, ehi, elo, hi, lo;
        logic [1:0] op;
        bit eill, ill, held;
        int elat, lat, bn;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            model(op, a, b, ehi, elo, eill, elat);
            do_op(op, a, b, lat, hi, lo, ill, bn, held);
            nvec++; if (lat !== elat) begin nfail++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, elat); end
            nvec++; if (hi !== ehi) begin nfail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, hi, ehi); end
            nvec++; if (lo !== elo) begin nfail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, lo, elo); end
            nvec++; if (ill !== eill) begin nfail++; $display("FAIL rnd%0d_illegal got=%b exp=%b", i, ill, eill); end
            nvec++; if (held !== 1'b1) begin nfail++; $display("FAIL rnd%0d_hilo_hold got=%b exp=1", i, held); end
            m_hi = ehi; m_lo = elo;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, e1hi, e1lo, e2hi, e2lo, h1, l1, h2, l2;
        bit eill, fin_stall;
        int elat, d1, d2, stall_n;
        a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
        model(OP_MULT, a1, b1, e1hi, e1lo, eill, elat);
        model(OP_MULTU, a2, b2, e2hi, e2lo, eill, elat);
        bus.start = 1'b1; bus.op = OP_MULT; bus.srca = a1; bus.srcb = b1;
        @(posedge clk);
        d1 = -1; stall_n = 0; fin_stall = 1'b1; h1 = 'x; l1 = 'x; h2 = 'x; l2 = 'x;
        for (int n = 1; n <= 40 && d1 < 0; n++) begin
            @(negedge clk);
            if (bus.done) begin
                d1 = n; h1 = bus.hiout; l1 = bus.loout; fin_stall = bus.stall;
                bus.op = OP_MULTU; bus.srca = a2; bus.srcb = b2;
            end else if (bus.stall) begin
                stall_n++;
            end
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        d2 = -1;
        for (int n = d1 + 1; n <= d1 + 40 && d2 < 0; n++) begin
            @(negedge clk);
            if (bus.done) begin d2 = n; h2 = bus.hiout; l2 = bus.loout; end
        end
        @(posedge clk);
        #1;
        nvec++; if (d1 !== 33) begin nfail++; $display("FAIL b2b_first_latency got=%0d exp=33", d1); end
        nvec++; if (stall_n !== 32) begin nfail++; $display("FAIL b2b_stall_cycles got=%0d exp=32", stall_n); end
        nvec++; if (fin_stall !== 1'b0) begin nfail++; $display("FAIL b2b_fin_stall got=%b exp=0", fin_stall); end
        nvec++; if (h1 !== e1hi || l1 !== e1lo) begin nfail++; $display("FAIL b2b_first_result got=%h_%h exp=%h_%h", h1, l1, e1hi, e1lo); end
        nvec++; if (d2 - d1 !== 33) begin nfail++; $display("FAIL b2b_gap got=%0d exp=33", d2 - d1); end
        nvec++; if (h2 !== e2hi || l2 !== e2lo) begin nfail++; $display("FAIL b2b_second_result got=%h_%h exp=%h_%h", h2, l2, e2hi, e2lo); end
        m_hi = e2hi; m_lo = e2lo;
    endtask

    task automatic test_reset_abort();
        logic [31:0] a, b, ehi, elo, hi, lo;
        bit eill, ill, held, seen;
        int elat, lat, bn;
        a = pick(); b = pick();
        bus.start = 1'b1; bus.op = OP_MULTU; bus.srca = a; bus.srcb = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        m_hi = '0; m_lo = '0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        nvec++; if (seen !== 1'b0) begin nfail++; $display("FAIL abort_done got=%b exp=0", seen); end
        nvec++; if (bus.hiout !== 32'd0 || bus.loout !== 32'd0) begin nfail++; $display("FAIL abort_hilo got=%h_%h exp=0_0", bus.hiout, bus.loout); end
        nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        @(posedge clk);
        #1;
        model(OP_MULTU, a, b, ehi, elo, eill, elat);
        do_op(OP_MULTU, a, b, lat, hi, lo, ill, bn, held);
        nvec++; if (lat !== 33) begin nfail++; $display("FAIL abort_restart_latency got=%0d exp=33", lat); end
        nvec++; if (hi !== ehi || lo !== elo) begin nfail++; $display("FAIL abort_restart_result got=%h_%h exp=%h_%h", hi, lo, ehi, elo); end
        m_hi = ehi; m_lo = elo;
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.op = OP_MULTU; bus.srca = '0; bus.srcb = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
